vga_frame_capture: RTL and testbench
====================================

// Module: vga_frame_capture
// PURPOSE
// - Receive end of the VGA pixel interface: samples sync/blank/pixel of an incoming 640x480 raster
//   and writes one frame (8-bit grayscale) into a framebuffer RAM via a write port.
// - Sits between an external/looped-back VGA source and the image memory the Pipeline later reads.
// PARAMETERS
// - H_ACTIVE  640  active pixels per line
// - V_ACTIVE  480  active lines per frame
// - ADDR_W    19   framebuffer address width (H_ACTIVE*V_ACTIVE <= 2**ADDR_W)
// PORTS
// - vgaclk           in   1       pixel clock (25 MHz); sole clock
// - reset            in   1       synchronous, active-low reset
// - horizontal_sync  in   1       incoming HS, active-low
// - vertical_sync    in   1       incoming VS, active-low
// - vga_blank        in   1       incoming BLANK_N: 1 = active pixel (data enable)
// - pixel_in         in   8       incoming pixel value
// - arm              in   1       1-cycle pulse: capture next full frame
// - continuo         in   1       1 = re-arm automatically after each frame
// - dimensiones      in   16      crop window [15:8]=width,[7:0]=height (used only with macro)
// - wr_en            out  1       framebuffer write strobe
// - wr_addr          out  ADDR_W  framebuffer write address
// - wr_data          out  8       framebuffer write data
// - busy             out  1       1 while in WAIT_VS or CAPTURE
// - frame_done       out  1       1-cycle pulse when a frame completed
// - frame_err        out  1       sticky: line/frame length mismatch; cleared by arm
// BEHAVIOUR
// - Reset (reset==0 on clk edge): state IDLE; wr_en/busy/frame_done/frame_err=0; wr_addr/wr_data=0; x,y=0.
// - Inputs registered once (stage s1) and once more (s2) for edge detect; vs_fall = s2.vs & ~s1.vs,
//   de_fall = s2.de & ~s1.de.
// - FSM: IDLE -arm-> WAIT_VS -vs_fall-> CAPTURE -line V_ACTIVE ends-> DONE -> (continuo ? WAIT_VS : IDLE).
// - CAPTURE: each cycle with s1.de=1 and x<H_ACTIVE: wr_en=1, wr_data=s1.pixel, wr_addr=y*H_ACTIVE+x
//   (incremental, no multiplier), x++. Latency pin->wr_en = 2 cycles.
// - de high with x==H_ACTIVE: pixel dropped, frame_err=1.
// - de_fall: if x!=H_ACTIVE set frame_err; x=0; y++. When y becomes V_ACTIVE -> DONE.
// - vs_fall in CAPTURE with y<V_ACTIVE: frame_err=1, x=y=0, stay CAPTURE (restart on new frame).
// - DONE lasts 1 cycle; frame_done=1 there only. busy=0 in IDLE and DONE.
// - arm while busy: ignored. arm in IDLE or DONE: clears frame_err, enters WAIT_VS.
// - arm coincident with vs_fall in IDLE: goes to WAIT_VS only (waits for next vs_fall).
// - Reset mid-capture: abort immediately, no further writes.
// - horizontal_sync sampled but only used for frame_err check: HS low while de=1 sets frame_err.
// CONFIGURATION
// - `VGA_CAPTURE_CROP_EN defined: only pixels x<width, y<height written; addr = y*width+x (packed);
//   width/height latched at vs_fall; width==0 or height==0 -> no writes, frame_done still pulses.
// - Undefined: dimensiones ignored, full H_ACTIVE x V_ACTIVE frame written.
// STRUCTURE
// - Package vga_capture_pkg: capture_state_t enum {IDLE,WAIT_VS,CAPTURE,DONE}, H_ACTIVE/V_ACTIVE defaults,
//   ADDR_W, shared with Vga timing constants.
// - Sub-module capture_addr_gen: x/y counters + incremental wr_addr (with crop logic under macro).
// TESTING
// - arm, one clean 640x480 frame, pixel=(x+y)&8'hFF -> 307200 writes, addr 0..307199, frame_done once, err=0.
// - Line 10 with 639 active pixels -> frame_err=1, frame still completes after line 479.
// - vs_fall after line 200 -> frame_err=1, addresses restart at 0, full next frame captured.
// - continuo=1, three frames -> three frame_done pulses, no arm between; continuo=0 -> IDLE after one.
// - reset=0 at pixel (320,240) -> wr_en=0 next cycle, state IDLE, all outputs 0.
// - CROP_EN, dimensiones=16'h4030 (64x48) -> 3072 writes, last addr 3071; dimensiones=16'h0030 -> 0 writes.

Source files
------------

// File: rtl/vga_frame_capture_pkg.sv
// rtl/vga_frame_capture_pkg.sv - capture state type and VGA raster constants
package vga_capture_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} capture_state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
endpackage

// File: rtl/vga_frame_capture_if.sv
// rtl/vga_frame_capture_if.sv - framebuffer write port
interface vga_frame_capture_if #(
    parameter int ADDR_W = 19
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/capture_addr_gen.sv
// rtl/capture_addr_gen.sv - raster x/y counters and incremental framebuffer address; crop window under `VGA_CAPTURE_CROP_EN
module capture_addr_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              de,
    input  logic              de_fall,
    input  logic              vs_fall,
    input  logic [15:0]       dimensiones,
    output logic              pix_ok,
    output logic              overflow,
    output logic              line_short,
    output logic              frame_end,
    output logic [ADDR_W-1:0] pix_addr
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] line_step;
    logic              in_window;
    logic              x_full;

`ifdef VGA_CAPTURE_CROP_EN
    logic [7:0] crop_w;
    logic [7:0] crop_h;

    // Window size is frozen at each frame start so a mid-frame change cannot tear the layout.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crop_w <= '0;
            crop_h <= '0;
        end else if (vs_fall) begin
            crop_w <= dimensiones[15:8];
            crop_h <= dimensiones[7:0];
        end
    end

    assign in_window = (32'(x) < 32'(crop_w)) && (32'(y) < 32'(crop_h));
    assign line_step = ADDR_W'(crop_w);
`else
    logic unused_dims;
    assign unused_dims = ^{vs_fall, dimensiones};
    assign in_window   = 1'b1;
    assign line_step   = ADDR_W'(H_ACTIVE);
`endif

    assign x_full     = (x == XW'(H_ACTIVE));
    assign pix_ok     = de && !x_full && in_window;
    assign overflow   = de && x_full;
    assign line_short = de_fall && !x_full;
    assign frame_end  = de_fall && (y == YW'(V_ACTIVE - 1));
    assign pix_addr   = line_base + ADDR_W'(x);

    // line_base tracks y*step by accumulation, so short lines still realign the next row.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
        end else if (de_fall) begin
            x         <= '0;
            y         <= y + YW'(1);
            line_base <= line_base + line_step;
        end else if (de && !x_full) begin
            x <= x + XW'(1);
        end
    end
endmodule

// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA receive side: grabs one grayscale frame into a framebuffer; crop under `VGA_CAPTURE_CROP_EN
module vga_frame_capture #(
    parameter int H_ACTIVE = vga_capture_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_capture_pkg::V_ACTIVE,
    parameter int ADDR_W   = vga_capture_pkg::ADDR_W
) (
    input  logic                vgaclk,
    input  logic                reset,
    input  logic                horizontal_sync,
    input  logic                vertical_sync,
    input  logic                vga_blank,
    input  logic [7:0]          pixel_in,
    input  logic                arm,
    input  logic                continuo,
    input  logic [15:0]         dimensiones,
    vga_frame_capture_if.master wr,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err
);
    import vga_capture_pkg::*;

    capture_state_t    state;
    logic              s1_hs, s1_vs, s1_de, s2_vs, s2_de;
    logic [7:0]        s1_pixel;
    logic              vs_fall, de_fall;
    logic              pix_ok, overflow, line_short, frame_end;
    logic [ADDR_W-1:0] pix_addr;

    always_ff @(posedge vgaclk) begin
        if (!reset) begin
            {s1_hs, s1_vs, s1_de, s2_vs, s2_de} <= '0;
            s1_pixel <= '0;
        end else begin
            s1_hs    <= horizontal_sync;
            s1_vs    <= vertical_sync;
            s1_de    <= vga_blank;
            s1_pixel <= pixel_in;
            s2_vs    <= s1_vs;
            s2_de    <= s1_de;
        end
    end

    assign vs_fall = s2_vs & ~s1_vs;
    assign de_fall = s2_de & ~s1_de;

    capture_addr_gen #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk        (vgaclk),
        .resetn     (reset),
        .clear      ((state != CAPTURE) || vs_fall),
        .de         (s1_de),
        .de_fall    (de_fall),
        .vs_fall    (vs_fall),
        .dimensiones(dimensiones),
        .pix_ok     (pix_ok),
        .overflow   (overflow),
        .line_short (line_short),
        .frame_end  (frame_end),
        .pix_addr   (pix_addr)
    );

    always_ff @(posedge vgaclk) begin
        if (!reset) begin
            state      <= IDLE;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr.wr_en   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= WAIT_VS;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    if (vs_fall) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (pix_ok) begin
                        wr.wr_en   <= 1'b1;
                        wr.wr_addr <= pix_addr;
                        wr.wr_data <= s1_pixel;
                    end
                    if (overflow || line_short || (s1_de && !s1_hs) || vs_fall)
                        frame_err <= 1'b1;
                    // A premature vsync restarts the frame instead of finishing it.
                    if (!vs_fall && frame_end) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (arm || continuo) begin
                        state <= WAIT_VS;
                        busy  <= 1'b1;
                        if (arm) frame_err <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb/tb_vga_frame_capture.sv - random-pixel raster frames checked against an arithmetic write-order model
`timescale 1ns/1ps
module tb_vga_frame_capture;
    localparam int H  = 16;
    localparam int V  = 12;
    localparam int AW = 8;

    logic        vgaclk = 1'b0;
    logic        reset = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        de = 1'b0;
    logic        arm = 1'b0;
    logic        continuo = 1'b0;
    logic [7:0]  pix = 8'd0;
    logic [15:0] dims = {8'(H), 8'(V)};
    logic        busy, frame_done, frame_err;

    vga_frame_capture_if #(.ADDR_W(AW)) wr ();

    vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .vgaclk         (vgaclk),
        .reset          (reset),
        .horizontal_sync(hs),
        .vertical_sync  (vs),
        .vga_blank      (de),
        .pixel_in       (pix),
        .arm            (arm),
        .continuo       (continuo),
        .dimensiones    (dims),
        .wr             (wr),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_err      (frame_err)
    );

    always #5 vgaclk = ~vgaclk;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int last_addr = -1;
    int cw = H;
    int ch = V;
    int w0, d0;
    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge vgaclk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (wr.wr_en === 1'b1) begin
            wr_cnt++;
            last_addr = int'(wr.wr_addr);
            if (exp_addr.size() == 0) begin
                chk("pending_expected_writes", 32'(exp_addr.size()), 32'd1);
            end else begin
                chk("wr_addr", 32'(wr.wr_addr), 32'(exp_addr.pop_front()));
                chk("wr_data", 32'(wr.wr_data), 32'(exp_data.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge vgaclk);
            #1;
        end
    endtask

    task automatic hblank();
        de = 1'b0; tick(2);
        hs = 1'b0; tick(2);
        hs = 1'b1; tick(2);
    endtask

    task automatic vsync();
        de = 1'b0; tick(2);
        vs = 1'b0; tick(2);
        vs = 1'b1; tick(4);
    endtask

    // cap: frame should land in memory; short_y: line one pixel short;
    // stop_y: cut the frame after this line; rst_y: pull reset mid-line at x=H/2.
    task automatic send_frame(input bit cap, input int short_y, input int stop_y, input int rst_y);
        vsync();
        for (int y = 0; y < V; y++) begin
            int n;
            n = (y == short_y) ? H - 1 : H;
            for (int x = 0; x < n; x++) begin
                if (y == rst_y && x == H / 2) begin
                    reset = 1'b0;
                    de = 1'b0;
                    tick();
                    return;
                end
                pix = 8'($urandom_range(0, 255));
                de = 1'b1;
                if (cap && x < cw && y < ch && !(y == rst_y && x >= H / 2 - 1)) begin
                    exp_addr.push_back(AW'(y * cw + x));
                    exp_data.push_back(pix);
                end
                tick();
            end
            hblank();
            if (y == stop_y) return;
        end
        tick(4);
    endtask

    initial begin
        tick(3);
        chk("rst_wr_en", 32'(wr.wr_en), 0);
        chk("rst_wr_addr", 32'(wr.wr_addr), 0);
        chk("rst_wr_data", 32'(wr.wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        reset = 1'b1;
        tick(2);

        arm = 1'b1; tick(); arm = 1'b0;
        chk("busy_after_arm", 32'(busy), 1);
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(1'b1, -1, -1, -1);
        chk("clean_writes", wr_cnt - w0, H * V);
        chk("clean_last_addr", last_addr, H * V - 1);
        chk("clean_done", done_cnt - d0, 1);
        chk("clean_err", 32'(frame_err), 0);
        chk("clean_idle", 32'(busy), 0);
        chk("clean_queue", exp_addr.size(), 0);

        arm = 1'b1; tick(); arm = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(1'b1, 3, -1, -1);
        chk("short_writes", wr_cnt - w0, H * V - 1);
        chk("short_done", done_cnt - d0, 1);
        chk("short_err", 32'(frame_err), 1);
        chk("short_queue", exp_addr.size(), 0);

        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_clears_err", 32'(frame_err), 0);
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(1'b1, -1, 5, -1);
        send_frame(1'b1, -1, -1, -1);
        chk("abort_writes", wr_cnt - w0, 6 * H + H * V);
        chk("abort_last_addr", last_addr, H * V - 1);
        chk("abort_done", done_cnt - d0, 1);
        chk("abort_err", 32'(frame_err), 1);
        chk("abort_queue", exp_addr.size(), 0);

        continuo = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        repeat (3) send_frame(1'b1, -1, -1, -1);
        chk("cont_writes", wr_cnt - w0, 3 * H * V);
        chk("cont_done", done_cnt - d0, 3);
        chk("cont_rearmed", 32'(busy), 1);
        continuo = 1'b0;
        d0 = done_cnt;
        send_frame(1'b1, -1, -1, -1);
        chk("single_done", done_cnt - d0, 1);
        chk("single_idle", 32'(busy), 0);
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(1'b0, -1, -1, -1);
        chk("idle_no_writes", wr_cnt - w0, 0);
        chk("idle_no_done", done_cnt - d0, 0);

        arm = 1'b1; tick(); arm = 1'b0;
        send_frame(1'b1, -1, -1, V / 2);
        chk("midrst_wr_en", 32'(wr.wr_en), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(frame_err), 0);
        chk("midrst_addr", 32'(wr.wr_addr), 0);
        chk("midrst_data", 32'(wr.wr_data), 0);
        chk("midrst_queue", exp_addr.size(), 0);
        reset = 1'b1;
        tick(2);
        w0 = wr_cnt;
        send_frame(1'b0, -1, -1, -1);
        chk("after_rst_no_writes", wr_cnt - w0, 0);

`ifdef VGA_CAPTURE_CROP_EN
        dims = 16'h0504; cw = 5; ch = 4;
        arm = 1'b1; tick(); arm = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(1'b1, -1, -1, -1);
        chk("crop_writes", wr_cnt - w0, 20);
        chk("crop_last_addr", last_addr, 19);
        chk("crop_done", done_cnt - d0, 1);
        dims = 16'h0004; cw = 0; ch = 4;
        arm = 1'b1; tick(); arm = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(1'b1, -1, -1, -1);
        chk("crop0_writes", wr_cnt - w0, 0);
        chk("crop0_done", done_cnt - d0, 1);
`endif

        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
